hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter: width, 32, width of performance counters.
REQ-002 SHALL have one clock, `clk`; reset `rst` is synchronous and active-low.
REQ-003 SHALL have the following ports, in this order:
- `clk  in  1  rising-edge clock.`
- `rst  in  1  synchronous active-low reset.`
- `IF_ID_rs1_i  in  rv32i_reg  rs1 of the instruction in ID.`
- `IF_ID_rs2_i  in  rv32i_reg  rs2 of the instruction in ID.`
- `ID_EX_rd_i  in  rv32i_reg  rd of the instruction in EX.`
- `ID_EX_mem_read_i  in  1  EX instruction is a load.`
- `br_taken_i  in  1  EX resolved a redirect (taken branch/jump).`
- `imem_read_i  in  1  fetch request outstanding.`
- `imem_resp_i  in  1  fetch response.`
- `dmem_read_i  in  1  MEM-stage load request.`
- `dmem_write_i  in  1  MEM-stage store request.`
- `dmem_resp_i  in  1  data response.`
- `pc_load_o  out  1  PC register enable.`
- `IF_ID_load_o  out  1  IF/ID register enable.`
- `ID_EX_load_o  out  1  ID/EX register enable.`
- `EX_MEM_load_o  out  1  EX/MEM register enable.`
- `MEM_WB_load_o  out  1  MEM/WB register enable.`
- `ID_EX_bubble_o  out  1  ID/EX loads a nop control word.`
- `IF_ID_flush_o  out  1  IF/ID loads a nop.`
- `ID_EX_flush_o  out  1  ID/EX loads a nop.`
- `stall_cycles_o  out  width  stall/bubble cycle count.`
- `flush_count_o  out  width  applied flush count.`

Function
REQ-004 SHALL compute `mem_stall = (imem_read_i & ~imem_resp_i) | ((dmem_read_i | dmem_write_i) & ~dmem_resp_i)` combinationally.
REQ-005 SHALL compute `load_use = ID_EX_mem_read_i & |ID_EX_rd_i & (ID_EX_rd_i == IF_ID_rs1_i | ID_EX_rd_i == IF_ID_rs2_i)`.
REQ-006 SHALL implement the states RUN, MEM_STALL and LU_BUBBLE in an `hazard_state_t` register.
REQ-007 SHALL, while `mem_stall` is high in any state, drive all five `*_load_o` outputs to 0 and the bubble/flush outputs to 0, and SHALL hold or enter MEM_STALL.
REQ-008 SHALL, in MEM_STALL, return to RUN on the first cycle `mem_stall` is low; that cycle is evaluated as a RUN cycle.
REQ-009 SHALL set the `flush_pending` register when `br_taken_i & mem_stall`.
REQ-010 SHALL clear `flush_pending` only when a flush is applied.
REQ-011 SHALL, in a RUN cycle with `~mem_stall & (br_taken_i | flush_pending)`, assert `IF_ID_flush_o` and `ID_EX_flush_o` and set all loads to 1; flush wins over `load_use`, and the state stays RUN.
REQ-012 SHALL, in a RUN cycle with `~mem_stall & load_use` and no flush, drive `pc_load_o=0`, `IF_ID_load_o=0`, `ID_EX_bubble_o=1`, and the remaining loads to 1, then go to LU_BUBBLE.
REQ-013 SHALL, in LU_BUBBLE without `mem_stall`, ignore `load_use`, apply any flush per REQ-011, and otherwise assert all loads; the next state is RUN, so exactly one bubble is inserted per load.
REQ-014 SHALL, in RUN with no stall, flush, or hazard, drive all loads to 1 and bubble/flush outputs to 0.
REQ-015 SHALL increment `stall_cycles_o` on each cycle with `mem_stall` or `ID_EX_bubble_o`.
REQ-016 SHALL increment `flush_count_o` on each applied flush.
REQ-017 SHALL saturate both counters at 2^width-1 with no wrap-around.

Reset
REQ-018 SHALL, on a clock edge with `rst` low, set the state to RUN, clear `flush_pending`, and clear both counters.
REQ-019 SHALL, while `rst` is low, drive all `*_load_o`, bubble and flush outputs to 0.
REQ-020 SHALL, on reset asserted mid-stall or mid-bubble, discard the operation; the first cycle after reset is a clean RUN cycle.

Configuration
REQ-021 SHALL, with `HAZARD_PERF_CNT_EN` defined, implement the counters of REQ-015..017.
REQ-022 SHALL, without `HAZARD_PERF_CNT_EN`, keep the counter ports but tie them to 0 and instantiate no counter flops; control behaviour SHALL be identical in both builds.

Structure
REQ-023 SHALL place `hazard_state_t` (RUN, MEM_STALL, LU_BUBBLE) in the shared `rv32i_types` package.
REQ-024 SHALL implement the counters with one sub-module, `sat_counter` (parameter width, ports clk, rst, inc_i, count_o), instantiated twice under `HAZARD_PERF_CNT_EN`.

Verification
REQ-025 SHALL cover a load-use stall:
- Stimulus: `ID_EX_mem_read_i=1`, `ID_EX_rd_i=5`, `IF_ID_rs2_i=5`, no mem stall.
- Response: one cycle of `pc_load_o=0`, `IF_ID_load_o=0`, `ID_EX_bubble_o=1`; the next cycle has all loads at 1 even if inputs persist; `stall_cycles_o=1`.
REQ-026 SHALL cover x0 as a load destination:
- Stimulus: `ID_EX_rd_i=0`, `IF_ID_rs1_i=0`, load in EX.
- Response: no bubble.
REQ-027 SHALL cover a data-cache miss:
- Stimulus: `dmem_read_i=1` with `dmem_resp_i=0` for 4 cycles, then 1.
- Response: all loads are 0 for 4 cycles, all loads are 1 on the response cycle, and `stall_cycles_o=4`.
REQ-028 SHALL cover a branch during a fetch miss:
- Stimulus: `br_taken_i` pulses while `imem_read_i=1` and `imem_resp_i=0`.
- Response: no flush during the stall; both flush outputs are 1 on the response cycle; `flush_count_o=1`; `flush_pending` is cleared.
REQ-029 SHALL cover a simultaneous flush and load-use:
- Stimulus: `br_taken_i=1` and `load_use=1`.
- Response: flush asserted, `ID_EX_bubble_o=0`, `pc_load_o=1`.
REQ-030 SHALL cover reset during MEM_STALL:
- Stimulus: `rst=0` for 1 cycle.
- Response: outputs are 0, and after release the state is RUN with counters at 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types.
//   rv32i_reg      : 5-bit architectural register index (x0..x31)
//   hazard_state_t : hazard controller states (RUN, MEM_STALL, LU_BUBBLE)
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_STALL = 2'd1,
    LU_BUBBLE = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-low reset, clears the count
//   inc_i   : increment request for this cycle
//   count_o : current count; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [width-1:0] count_o
);

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  logic [width-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (inc_i && (count_reg != '1)) begin
      count_reg <= count_reg + ONE;
    end
  end

  assign count_o = count_reg;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for a 5-stage RV32I core.
// Freezes the whole pipeline on instruction/data memory misses, inserts a
// single bubble for load-use hazards, and flushes IF/ID and ID/EX on taken
// redirects. A redirect seen during a memory stall is remembered and applied
// on the first unstalled cycle.
//
// Ports:
//   clk, rst                    : clock, synchronous active-low reset
//   IF_ID_rs1_i/IF_ID_rs2_i     : source registers of the ID instruction
//   ID_EX_rd_i/ID_EX_mem_read_i : destination / load flag of the EX instruction
//   br_taken_i                  : EX resolved a taken branch or jump
//   imem_read_i/imem_resp_i     : fetch request / response
//   dmem_read_i/dmem_write_i/dmem_resp_i : MEM-stage request / response
//   *_load_o                    : pipeline register enables
//   ID_EX_bubble_o              : ID/EX captures a nop control word
//   IF_ID_flush_o/ID_EX_flush_o : IF/ID and ID/EX capture a nop
//   stall_cycles_o/flush_count_o: saturating performance counters
//
// Build option: define HAZARD_PERF_CNT_EN to implement the performance
// counters; without it the counter ports read 0 and no counter flops exist.
module hazard_controller
  import rv32i_types::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  rv32i_reg         IF_ID_rs1_i,
  input  rv32i_reg         IF_ID_rs2_i,
  input  rv32i_reg         ID_EX_rd_i,
  input  logic             ID_EX_mem_read_i,
  input  logic             br_taken_i,
  input  logic             imem_read_i,
  input  logic             imem_resp_i,
  input  logic             dmem_read_i,
  input  logic             dmem_write_i,
  input  logic             dmem_resp_i,
  output logic             pc_load_o,
  output logic             IF_ID_load_o,
  output logic             ID_EX_load_o,
  output logic             EX_MEM_load_o,
  output logic             MEM_WB_load_o,
  output logic             ID_EX_bubble_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_flush_o,
  output logic [width-1:0] stall_cycles_o,
  output logic [width-1:0] flush_count_o
);

  hazard_state_t state_reg, state_next;
  logic          flush_pending_reg, flush_pending_next;
  logic          mem_stall;
  logic          load_use;
  logic          flush_req;

  assign mem_stall = (imem_read_i & ~imem_resp_i)
                   | ((dmem_read_i | dmem_write_i) & ~dmem_resp_i);

  // x0 never carries a loaded value, so it cannot create a hazard.
  assign load_use = ID_EX_mem_read_i & (|ID_EX_rd_i)
                  & ((ID_EX_rd_i == IF_ID_rs1_i) | (ID_EX_rd_i == IF_ID_rs2_i));

  assign flush_req = br_taken_i | flush_pending_reg;

  // Enables must react in the same cycle a miss is seen, so the control
  // word is decoded combinationally from the current state and inputs.
  always_comb begin
    pc_load_o          = 1'b0;
    IF_ID_load_o       = 1'b0;
    ID_EX_load_o       = 1'b0;
    EX_MEM_load_o      = 1'b0;
    MEM_WB_load_o      = 1'b0;
    ID_EX_bubble_o     = 1'b0;
    IF_ID_flush_o      = 1'b0;
    ID_EX_flush_o      = 1'b0;
    state_next         = state_reg;
    flush_pending_next = flush_pending_reg;

    if (!rst) begin
      state_next         = RUN;
      flush_pending_next = 1'b0;
    end else if (mem_stall) begin
      // Freeze everything; a redirect arriving now is deferred.
      state_next = MEM_STALL;
      if (br_taken_i) begin
        flush_pending_next = 1'b1;
      end
    end else begin
      // MEM_STALL with the miss resolved behaves exactly like RUN.
      pc_load_o     = 1'b1;
      IF_ID_load_o  = 1'b1;
      ID_EX_load_o  = 1'b1;
      EX_MEM_load_o = 1'b1;
      MEM_WB_load_o = 1'b1;
      state_next    = RUN;
      if (flush_req) begin
        // The flush squashes the ID instruction, so a load-use bubble is moot.
        IF_ID_flush_o      = 1'b1;
        ID_EX_flush_o      = 1'b1;
        flush_pending_next = 1'b0;
      end else if (load_use && (state_reg != LU_BUBBLE)) begin
        // The dependent instruction stays in ID for exactly one cycle; in
        // LU_BUBBLE the load has moved on and forwarding covers it.
        pc_load_o      = 1'b0;
        IF_ID_load_o   = 1'b0;
        ID_EX_bubble_o = 1'b1;
        state_next     = LU_BUBBLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= RUN;
      flush_pending_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      flush_pending_reg <= flush_pending_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc;

  assign stall_inc = mem_stall | ID_EX_bubble_o;

  sat_counter #(.width(width)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall_inc),
    .count_o (stall_cycles_o)
  );

  sat_counter #(.width(width)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (IF_ID_flush_o),
    .count_o (flush_count_o)
  );
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of the pipeline-control rules.
module tb_hazard_controller;
  import rv32i_types::*;

  localparam int W = 4;
  localparam int CNT_MAX = (1 << W) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  rv32i_reg       IF_ID_rs1_i, IF_ID_rs2_i, ID_EX_rd_i;
  logic           ID_EX_mem_read_i, br_taken_i;
  logic           imem_read_i, imem_resp_i;
  logic           dmem_read_i, dmem_write_i, dmem_resp_i;
  logic           pc_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o;
  logic           ID_EX_bubble_o, IF_ID_flush_o, ID_EX_flush_o;
  logic [W-1:0]   stall_cycles_o, flush_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_controller #(.width(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .IF_ID_rs1_i      (IF_ID_rs1_i),
    .IF_ID_rs2_i      (IF_ID_rs2_i),
    .ID_EX_rd_i       (ID_EX_rd_i),
    .ID_EX_mem_read_i (ID_EX_mem_read_i),
    .br_taken_i       (br_taken_i),
    .imem_read_i      (imem_read_i),
    .imem_resp_i      (imem_resp_i),
    .dmem_read_i      (dmem_read_i),
    .dmem_write_i     (dmem_write_i),
    .dmem_resp_i      (dmem_resp_i),
    .pc_load_o        (pc_load_o),
    .IF_ID_load_o     (IF_ID_load_o),
    .ID_EX_load_o     (ID_EX_load_o),
    .EX_MEM_load_o    (EX_MEM_load_o),
    .MEM_WB_load_o    (MEM_WB_load_o),
    .ID_EX_bubble_o   (ID_EX_bubble_o),
    .IF_ID_flush_o    (IF_ID_flush_o),
    .ID_EX_flush_o    (ID_EX_flush_o),
    .stall_cycles_o   (stall_cycles_o),
    .flush_count_o    (flush_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state: a deferred redirect, whether the previous cycle already
  // inserted a load-use bubble, and the two event counts.
  bit m_pending = 0;
  bit m_bubbled = 0;
  int m_stalls  = 0;
  int m_flushes = 0;
  bit m_valid   = 0;

  // Control word order: pc, if_id, id_ex, ex_mem, mem_wb, bubble, if_flush, id_flush
  always @(negedge clk) begin
    bit stall, hazard, redirect;
    logic [7:0] exp_w, act_w;
    stall    = (imem_read_i && !imem_resp_i) ||
               ((dmem_read_i || dmem_write_i) && !dmem_resp_i);
    hazard   = ID_EX_mem_read_i && (ID_EX_rd_i != 0) &&
               (ID_EX_rd_i == IF_ID_rs1_i || ID_EX_rd_i == IF_ID_rs2_i);
    redirect = br_taken_i || m_pending;

    if (!rst || stall)               exp_w = 8'b00000000;
    else if (redirect)               exp_w = 8'b11111011;
    else if (hazard && !m_bubbled)   exp_w = 8'b00111100;
    else                             exp_w = 8'b11111000;

    act_w = {pc_load_o, IF_ID_load_o, ID_EX_load_o, EX_MEM_load_o, MEM_WB_load_o,
             ID_EX_bubble_o, IF_ID_flush_o, ID_EX_flush_o};
    check("ctrl_word", int'(act_w), int'(exp_w));
    if (m_valid) begin
      check("stall_cycles", int'(stall_cycles_o), CNT_EN ? m_stalls : 0);
      check("flush_count",  int'(flush_count_o),  CNT_EN ? m_flushes : 0);
    end

    // Advance the model to the state after the coming edge.
    if (!rst) begin
      m_pending = 0; m_bubbled = 0; m_stalls = 0; m_flushes = 0; m_valid = 1;
    end else begin
      if (stall || exp_w[2]) m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
      if (exp_w[1])          m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
      if (stall) begin
        if (br_taken_i) m_pending = 1;
        m_bubbled = 0;
      end else begin
        if (redirect) m_pending = 0;
        m_bubbled = exp_w[2];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IF_ID_rs1_i = 0; IF_ID_rs2_i = 0; ID_EX_rd_i = 0;
    ID_EX_mem_read_i = 0; br_taken_i = 0;
    imem_read_i = 0; imem_resp_i = 0;
    dmem_read_i = 0; dmem_write_i = 0; dmem_resp_i = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    #2;
    check("reset_pc_load", int'(pc_load_o), 0);
    tick();
    rst = 1;
  endtask

  initial begin
    rst = 0;
    idle();
    tick();

    // Load-use: one bubble, then all loads even with the hazard still present.
    $display("scenario: load-use stall");
    do_reset();
    ID_EX_mem_read_i = 1; ID_EX_rd_i = 5; IF_ID_rs2_i = 5; IF_ID_rs1_i = 1;
    #2;
    check("lu_pc_load", int'(pc_load_o), 0);
    check("lu_ifid_load", int'(IF_ID_load_o), 0);
    check("lu_bubble", int'(ID_EX_bubble_o), 1);
    tick(); #2;
    check("lu_next_pc_load", int'(pc_load_o), 1);
    check("lu_next_bubble", int'(ID_EX_bubble_o), 0);
    check("lu_stall_cnt", int'(stall_cycles_o), CNT_EN ? 1 : 0);

    // x0 destination never stalls.
    $display("scenario: x0 load destination");
    do_reset();
    ID_EX_mem_read_i = 1; ID_EX_rd_i = 0; IF_ID_rs1_i = 0;
    #2;
    check("x0_bubble", int'(ID_EX_bubble_o), 0);
    check("x0_pc_load", int'(pc_load_o), 1);

    // Data-cache miss for four cycles.
    $display("scenario: dcache miss");
    do_reset();
    dmem_read_i = 1; dmem_resp_i = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("dmiss_pc_load", int'(pc_load_o), 0);
      check("dmiss_memwb_load", int'(MEM_WB_load_o), 0);
      tick();
    end
    dmem_resp_i = 1;
    #2;
    check("dmiss_resp_memwb", int'(MEM_WB_load_o), 1);
    check("dmiss_resp_pc", int'(pc_load_o), 1);
    check("dmiss_stall_cnt", int'(stall_cycles_o), CNT_EN ? 4 : 0);

    // Redirect during a fetch miss is deferred to the response cycle.
    $display("scenario: branch during fetch miss");
    do_reset();
    imem_read_i = 1; imem_resp_i = 0; br_taken_i = 1;
    #2;
    check("bmiss_no_flush", int'(IF_ID_flush_o), 0);
    tick(); br_taken_i = 0; #2;
    check("bmiss_no_flush2", int'(ID_EX_flush_o), 0);
    tick(); imem_resp_i = 1; #2;
    check("bmiss_ifid_flush", int'(IF_ID_flush_o), 1);
    check("bmiss_idex_flush", int'(ID_EX_flush_o), 1);
    tick(); idle(); #2;
    check("bmiss_pending_clr", int'(IF_ID_flush_o), 0);
    check("bmiss_flush_cnt", int'(flush_count_o), CNT_EN ? 1 : 0);

    // Flush beats load-use.
    $display("scenario: flush with load-use");
    do_reset();
    br_taken_i = 1; ID_EX_mem_read_i = 1; ID_EX_rd_i = 7; IF_ID_rs1_i = 7;
    #2;
    check("fl_lu_flush", int'(IF_ID_flush_o), 1);
    check("fl_lu_bubble", int'(ID_EX_bubble_o), 0);
    check("fl_lu_pc_load", int'(pc_load_o), 1);

    // Reset in the middle of a stall and of a bubble.
    $display("scenario: reset mid-stall / mid-bubble");
    do_reset();
    dmem_write_i = 1; dmem_resp_i = 0;
    tick(); tick();
    rst = 0; #2;
    check("rst_stall_memwb", int'(MEM_WB_load_o), 0);
    check("rst_stall_pc", int'(pc_load_o), 0);
    tick(); rst = 1; dmem_write_i = 0; #2;
    check("rst_release_pc", int'(pc_load_o), 1);
    check("rst_release_cnt", int'(stall_cycles_o), 0);
    ID_EX_mem_read_i = 1; ID_EX_rd_i = 3; IF_ID_rs1_i = 3;
    tick(); rst = 0;
    tick(); rst = 1; #2;
    check("rst_bubble_fresh", int'(ID_EX_bubble_o), 1);

    // Counter saturation.
    $display("scenario: counter saturation");
    do_reset();
    dmem_read_i = 1; dmem_resp_i = 0; br_taken_i = 1;
    repeat (CNT_MAX + 5) tick();
    dmem_read_i = 0;
    repeat (CNT_MAX + 5) tick();
    #2;
    check("sat_stall_cnt", int'(stall_cycles_o), CNT_EN ? CNT_MAX : 0);
    check("sat_flush_cnt", int'(flush_count_o), CNT_EN ? CNT_MAX : 0);

    // Randomized phase.
    $display("scenario: random traffic");
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 59) != 0);
      IF_ID_rs1_i      = rv32i_reg'($urandom_range(0, 3));
      IF_ID_rs2_i      = rv32i_reg'($urandom_range(0, 3));
      ID_EX_rd_i       = rv32i_reg'($urandom_range(0, 3));
      ID_EX_mem_read_i = $urandom_range(0, 1) != 0;
      br_taken_i       = $urandom_range(0, 4) == 0;
      imem_read_i      = $urandom_range(0, 1) != 0;
      imem_resp_i      = $urandom_range(0, 2) != 0;
      dmem_read_i      = $urandom_range(0, 3) == 0;
      dmem_write_i     = $urandom_range(0, 5) == 0;
      dmem_resp_i      = $urandom_range(0, 2) != 0;
      tick();
    end
    idle();
    rst = 1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
